// File: rtl/vector_sweep_checker.sv
`timescale 1ns / 1ps
// vector_sweep_checker
//   Applies every input vector (or an inclusive range lo..hi) to a combinational circuit under
//   test. Each vector is held SETTLE cycles, then resp is compared against expected. The checker
//   reports how many vectors mismatched and captures the first failing vector and its response.
//
// Ports
//   clock           rising-edge clock
//   reset_b         asynchronous active-low reset
//   start           begin a sweep (honoured in idle only)
//   mode            0: exhaustive 0..2^N_IN-1, 1: ranged lo..hi
//   lo, hi          range bounds, captured at start
//   stim            vector driven into the circuit under test
//   resp            circuit under test outputs
//   expected        golden-model outputs for the current stim
//   busy            sweep in progress
//   done            one-cycle pulse after the final sample edge
//   err_count       mismatching vectors in the last sweep (saturating)
//   err_seen        at least one mismatch in the last sweep
//   first_err_stim  stim of the first mismatch
//   first_err_resp  resp captured at the first mismatch
module vector_sweep_checker #(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned N_OUT  = 3,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned CNT_W  = N_IN + 1
) (
  input  logic              clock,
  input  logic              reset_b,
  input  logic              start,
  input  logic              mode,
  input  logic [N_IN-1:0]   lo,
  input  logic [N_IN-1:0]   hi,
  output logic [N_IN-1:0]   stim,
  input  logic [N_OUT-1:0]  resp,
  input  logic [N_OUT-1:0]  expected,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  err_count,
  output logic              err_seen,
  output logic [N_IN-1:0]   first_err_stim,
  output logic [N_OUT-1:0]  first_err_resp
);

  // Settle counter only has to reach SETTLE-1; keep at least one bit for SETTLE=1.
  localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SettleReload = SW'(SETTLE - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e          state_q;
  logic [SW-1:0]   cnt_q;
  logic [N_IN-1:0] last_q;

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      last_q         <= '0;
      stim           <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_count      <= '0;
      err_seen       <= 1'b0;
      first_err_stim <= '0;
      first_err_resp <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            err_count      <= '0;
            err_seen       <= 1'b0;
            first_err_stim <= '0;
            first_err_resp <= '0;
            if (mode && (lo > hi)) begin
              // Empty range: report completion immediately, stim untouched.
              done <= 1'b1;
            end else begin
              stim    <= mode ? lo : '0;
              last_q  <= mode ? hi : '1;
              busy    <= 1'b1;
              cnt_q   <= SettleReload;
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - SW'(1);
          end else begin
            if (resp != expected) begin
              if (err_count != '1) begin
                err_count <= err_count + CNT_W'(1);
              end
              err_seen <= 1'b1;
              if (!err_seen) begin
                first_err_stim <= stim;
                first_err_resp <= resp;
              end
            end
            // Compare against the latched last vector so the all-ones case ends without wrapping.
            if (stim == last_q) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              state_q <= StIdle;
            end else begin
              stim  <= stim + N_IN'(1);
              cnt_q <= SettleReload;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_sweep_checker.sv
`timescale 1ns / 1ps
module tb_vector_sweep_checker;

  logic       clock = 1'b0;
  logic       reset_b;
  logic       start, mode;
  logic [3:0] lo, hi, stim;
  logic [2:0] resp, expected;
  logic       busy, done, err_seen;
  logic [4:0] err_count;
  logic [3:0] first_err_stim;
  logic [2:0] first_err_resp;

  // Second instance: SETTLE=1, every vector mismatches.
  logic       start1, mode1;
  logic [3:0] lo1, hi1, stim1;
  logic [2:0] resp1, expected1;
  logic       busy1, done1, err_seen1;
  logic [4:0] err_count1;
  logic [3:0] first_err_stim1;
  logic [2:0] first_err_resp1;

  int checks   = 0;
  int failures = 0;

  logic [2:0] fault_mask [16];
  logic [3:0] model_stim;

  always #5 clock = ~clock;

  // Combinational "problem circuit" golden model.
  function automatic logic [2:0] gold(input logic [3:0] s);
    return {^s, s[3] & s[0], s[2] | s[1]};
  endfunction

  assign expected  = gold(stim);
  assign resp      = gold(stim) ^ fault_mask[stim];
  assign expected1 = gold(stim1);
  assign resp1     = gold(stim1) ^ 3'b111;

  vector_sweep_checker #(.N_IN(4), .N_OUT(3), .SETTLE(2), .CNT_W(5)) dut (
    .clock(clock), .reset_b(reset_b), .start(start), .mode(mode), .lo(lo), .hi(hi),
    .stim(stim), .resp(resp), .expected(expected), .busy(busy), .done(done),
    .err_count(err_count), .err_seen(err_seen), .first_err_stim(first_err_stim),
    .first_err_resp(first_err_resp)
  );

  vector_sweep_checker #(.N_IN(4), .N_OUT(3), .SETTLE(1), .CNT_W(5)) dut1 (
    .clock(clock), .reset_b(reset_b), .start(start1), .mode(mode1), .lo(lo1), .hi(hi1),
    .stim(stim1), .resp(resp1), .expected(expected1), .busy(busy1), .done(done1),
    .err_count(err_count1), .err_seen(err_seen1), .first_err_stim(first_err_stim1),
    .first_err_resp(first_err_resp1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h, required 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic set_faults(input logic [15:0] bitmap);
    for (int v = 0; v < 16; v++) fault_mask[v] = bitmap[v] ? 3'b001 : 3'b000;
  endtask

  // Reference: which vectors a sweep visits, how long busy lasts, and which ones fail.
  task automatic model(input logic m, input logic [3:0] l, input logic [3:0] h,
                       output int len, output int cnt, output logic [3:0] fst);
    int a, b;
    a = m ? int'(l) : 0;
    b = m ? int'(h) : 15;
    len = 0; cnt = 0; fst = 4'd0;
    for (int v = a; v <= b; v++) begin
      len += 2;
      if (fault_mask[v] != 3'b000) begin
        if (cnt == 0) fst = 4'(v);
        cnt++;
      end
    end
  endtask

  // Runs one sweep on dut, checking stim/busy/done every cycle and the results afterwards.
  // disturb: re-assert start and scramble mode/lo/hi during the run.
  task automatic sweep(input logic m, input logic [3:0] l, input logic [3:0] h,
                       input int len, input int cnt, input logic [3:0] fst, input bit disturb);
    logic [3:0] first, last, exp_stim;
    first = m ? l : 4'd0;
    last  = m ? h : 4'hF;
    @(negedge clock);
    mode = m; lo = l; hi = h; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int j = 0; j <= len; j++) begin
      if (j < len) exp_stim = first + 4'(j / 2);
      else         exp_stim = (len == 0) ? model_stim : last;
      chk("cycle_busy_done_stim", {busy, done, stim}, {(j < len), (j == len), exp_stim});
      if (disturb && j == 9) begin
        start = 1'b1; mode = ~m; lo = ~l; hi = ~h;
      end
      if (disturb && j == 10) start = 1'b0;
      if (j < len) @(negedge clock);
    end
    if (len > 0) model_stim = last;
    @(negedge clock);
    chk("done_single_pulse", {busy, done}, 2'b00);
    chk("err_count", err_count, cnt);
    chk("err_seen", err_seen, (cnt != 0));
    chk("first_err_stim", first_err_stim, (cnt != 0) ? fst : 4'd0);
    chk("first_err_resp", first_err_resp, (cnt != 0) ? (gold(fst) ^ fault_mask[fst]) : 3'd0);
  endtask

  typedef struct {
    logic        m;
    logic [3:0]  l;
    logic [3:0]  h;
    logic [15:0] faults;
    int          len;
    int          cnt;
    logic [3:0]  fst;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         len, cnt, bcnt, dcnt;
    logic [3:0] fst, rl, rh;
    logic       rm;

    tbl[0] = '{1'b0, 4'd0,  4'd0,  16'h0000, 32, 0, 4'd0};
    tbl[1] = '{1'b0, 4'd0,  4'd0,  16'h1020, 32, 2, 4'd5};
    tbl[2] = '{1'b1, 4'd3,  4'd3,  16'h0000,  2, 0, 4'd0};
    tbl[3] = '{1'b1, 4'd9,  4'd4,  16'hFFFF,  0, 0, 4'd0};
    tbl[4] = '{1'b1, 4'd2,  4'd7,  16'h1020, 12, 1, 4'd5};
    tbl[5] = '{1'b1, 4'd13, 4'd15, 16'h4001,  6, 1, 4'd14};

    reset_b = 1'b0;
    start = 1'b0; mode = 1'b0; lo = 4'd0; hi = 4'd0;
    start1 = 1'b0; mode1 = 1'b0; lo1 = 4'd0; hi1 = 4'd0;
    model_stim = 4'd0;
    set_faults(16'h0000);

    #12;
    chk("reset_state", {stim, busy, done, err_count, err_seen, first_err_stim, first_err_resp},
        '0);
    chk("reset_state_dut1", {stim1, busy1, done1, err_count1, err_seen1, first_err_stim1,
        first_err_resp1}, '0);
    @(negedge clock);
    reset_b = 1'b1;

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      set_faults(tbl[i].faults);
      sweep(tbl[i].m, tbl[i].l, tbl[i].h, tbl[i].len, tbl[i].cnt, tbl[i].fst, 1'b0);
    end

    // Start re-asserted and range inputs changed mid-run: ignored.
    set_faults(16'h1020);
    sweep(1'b0, 4'd0, 4'd0, 32, 2, 4'd5, 1'b1);

    // Start held high through done: a new sweep begins right after.
    set_faults(16'h0000);
    @(negedge clock);
    mode = 1'b1; lo = 4'd3; hi = 4'd3; start = 1'b1;
    @(negedge clock); chk("held_j0", {busy, done, stim}, {2'b10, 4'd3});
    @(negedge clock); chk("held_j1", {busy, done, stim}, {2'b10, 4'd3});
    @(negedge clock); chk("held_done", {busy, done, stim}, {2'b01, 4'd3});
    @(negedge clock); chk("held_restart", {busy, done, stim}, {2'b10, 4'd3});
    start = 1'b0;
    @(negedge clock); chk("held_j4", {busy, done}, 2'b10);
    @(negedge clock); chk("held_done2", {busy, done}, 2'b01);
    @(negedge clock); chk("held_idle", {busy, done}, 2'b00);
    model_stim = 4'd3;

    // Asynchronous reset in the 7th busy cycle.
    set_faults(16'h0021);
    @(negedge clock);
    mode = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int j = 0; j < 6; j++) @(negedge clock);
    chk("pre_reset_progress", {busy, stim, err_count}, {1'b1, 4'd3, 5'd1});
    #2 reset_b = 1'b0;
    #1;
    chk("async_reset_zero", {stim, busy, done, err_count, err_seen, first_err_stim,
        first_err_resp}, '0);
    @(negedge clock);
    reset_b = 1'b1;
    model_stim = 4'd0;
    for (int j = 0; j < 3; j++) begin
      chk("no_done_after_reset", {busy, done}, 2'b00);
      @(negedge clock);
    end
    sweep(1'b0, 4'd0, 4'd0, 32, 2, 4'd0, 1'b0);

    // Randomized sweeps against the reference model.
    for (int r = 0; r < 10; r++) begin
      for (int v = 0; v < 16; v++)
        fault_mask[v] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      rm = 1'($urandom_range(0, 1));
      rl = 4'($urandom_range(0, 15));
      rh = 4'($urandom_range(0, 15));
      model(rm, rl, rh, len, cnt, fst);
      sweep(rm, rl, rh, len, cnt, fst, 1'b0);
    end

    // SETTLE=1, every vector wrong.
    @(negedge clock);
    start1 = 1'b1;
    @(negedge clock);
    start1 = 1'b0;
    bcnt = 0; dcnt = 0;
    for (int j = 0; j < 40; j++) begin
      if (busy1) bcnt++;
      if (done1) dcnt++;
      @(negedge clock);
    end
    chk("s1_busy_cycles", bcnt, 16);
    chk("s1_done_pulses", dcnt, 1);
    chk("s1_err_count", err_count1, 5'd16);
    chk("s1_err_seen", err_seen1, 1'b1);
    chk("s1_first_err_stim", first_err_stim1, 4'd0);
    chk("s1_first_err_resp", first_err_resp1, gold(4'd0) ^ 3'b111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vector_sweep_checker.md
Name: vector_sweep_checker

Overview:
- Parametrised clocked successor to the course's hand-written combinational test stimulus.
- Drives every input vector, or a programmable range of vectors, into a combinational problem circuit.
- Holds each vector for a settle time, then samples the circuit's outputs and compares them against a golden-model output.
- Reports an error count and the first failing vector; used as an on-chip self-checker for the textbook combinational problem modules.

Parameters:
- N_IN, 4: width of stimulus vector (number of circuit inputs), ≥1
- N_OUT, 3: width of response/expected vectors (number of circuit outputs), ≥1
- SETTLE, 2: clock cycles each vector is held before sampling, ≥1
- CNT_W, N_IN+1: width of err_count; default holds 2^N_IN without overflow

Ports:
- clock  in  1  rising-edge clock
- reset_b  in  1  asynchronous active-low reset
- start  in  1  begin a sweep; sampled in IDLE only
- mode  in  1  0 = exhaustive sweep 0..2^N_IN-1; 1 = ranged sweep lo..hi
- lo  in  N_IN  first vector in ranged mode; captured at start
- hi  in  N_IN  last vector in ranged mode; captured at start
- stim  out  N_IN  vector applied to the circuit under test
- resp  in  N_OUT  circuit under test outputs
- expected  in  N_OUT  golden-model outputs for current stim
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at end of sweep
- err_count  out  CNT_W  number of mismatching vectors in last sweep
- err_seen  out  1  at least one mismatch in last sweep
- first_err_stim  out  N_IN  stim of first mismatch
- first_err_resp  out  N_OUT  resp captured at first mismatch

Behaviour:
- Reset (reset_b low, asynchronous): state IDLE; stim, busy, done, err_count, err_seen, first_err_stim, first_err_resp all 0; internal settle counter 0.
- States: IDLE, RUN.
- IDLE with start=1 at edge k:
  - Clear err_count, err_seen, first_err_*.
  - Latch first = (mode ? lo : 0) and last = (mode ? hi : all-ones).
  - If mode=1 and lo>hi (unsigned): no vectors are applied; done=1 for the cycle after edge k; busy stays 0; stim unchanged.
  - Otherwise: stim<=first, busy<=1, settle counter<=SETTLE-1, go to RUN.
- RUN, per edge:
  - If counter≠0: decrement; stim held.
  - If counter=0 (sample edge): compare resp against expected.
    - Mismatch: err_count<=err_count+1, saturating at all-ones; err_seen<=1.
    - First mismatch only: also capture first_err_stim<=stim and first_err_resp<=resp.
    - If stim==last: busy<=0, done<=1, go to IDLE; stim holds last value with no wrap to 0.
    - Else: stim<=stim+1, counter<=SETTLE-1.
- Timing: each vector is held exactly SETTLE cycles. For V vectors, busy is high for V*SETTLE cycles, and done pulses in the cycle after the final sample edge.
- done is high for exactly one cycle. Results hold stable until the next accepted start.
- start while busy: ignored; no restart. start held high in IDLE after done: a new sweep begins.
- lo/hi/mode changes during RUN: ignored (latched values used).
- Exhaustive mode at stim=2^N_IN-1 terminates; the counter never overflows into a repeat.
- reset_b asserted mid-sweep: immediate return to reset values; no done pulse.

Test Plan:
- N_IN=4, N_OUT=3, SETTLE=2, resp tied to expected; mode=0, pulse start → stim steps 0..15, two cycles each; busy high 32 cycles; done pulses once; err_count=0, err_seen=0.
- Same setup, resp = expected^3'b001 only when stim=5 and stim=12 → err_count=2, err_seen=1, first_err_stim=5, first_err_resp=expected(5)^1.
- mode=1, lo=3, hi=3 → a single vector 3 held 2 cycles; done 3 cycles after start edge; with lo=9, hi=4 → done next cycle, busy never high, err_count=0.
- Assert start again at the 10th busy cycle, and change lo/hi mid-run → sweep unaffected; single done at cycle 32.
- Drop reset_b at the 7th busy cycle, asynchronously between edges → outputs zero immediately; no done; a fresh start afterwards completes a normal 32-cycle sweep.
- SETTLE=1 with resp mismatching every vector → err_count=16 (CNT_W=5), first_err_stim=0, busy for 16 cycles.
